// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and op-class helpers for alu_seq.
// DIVU/REMU only count as iterative ops when ALU_SEQ_DIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b0110;
    localparam logic [3:0] OP_MULHU = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1001;
    localparam logic [3:0] OP_SRL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        case (op)
            OP_MUL, OP_MULHU: return 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU, OP_REMU: return 1'b1;
`endif
            default:          return 1'b0;
        endcase
    endfunction

    // High half of the shared hi/lo register pair holds MULHU and REMU results.
    function automatic logic md_sel_hi(input logic [3:0] op);
        return (op == OP_MULHU) || (op == OP_REMU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing a hi/lo register pair.
// The divider datapath exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic            r_busy;
    logic            r_sel_hi;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;
    logic [XLEN:0]   w_sum;

    // Multiply: {hi,lo} starts as {0,B}; add A to hi when lo[0] is set, then shift right.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN + 1){1'b0}});

`ifdef ALU_SEQ_DIV_EN
    logic            r_is_div;
    logic [XLEN-1:0] r_b;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;

    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_ge     = ~w_diff[XLEN];

    always_comb begin
        w_hi_nxt = w_sum[XLEN:1];
        w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        if (r_is_div) begin
            w_hi_nxt = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
        end
    end
`else
    always_comb begin
        w_hi_nxt = w_sum[XLEN:1];
        w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_sel_hi <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef ALU_SEQ_DIV_EN
            r_is_div <= 1'b0;
            r_b      <= '0;
`endif
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_sel_hi <= md_sel_hi(i_op);
            r_cnt    <= '0;
            r_a      <= i_a;
            r_hi     <= '0;
`ifdef ALU_SEQ_DIV_EN
            r_is_div <= md_is_div(i_op);
            r_b      <= i_b;
            r_lo     <= md_is_div(i_op) ? i_a : i_b;
`else
            r_lo     <= i_b;
`endif
        end else if (r_busy) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    // The final step's result is offered combinationally so the parent captures it on that edge.
    assign o_busy   = r_busy;
    assign o_done   = r_busy && (r_cnt == LAST);
    assign o_result = r_sel_hi ? w_hi_nxt : w_lo_nxt;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift/compare ops plus iterative MUL/MULHU/DIVU/REMU.
// Define ALU_SEQ_DIV_EN to enable DIVU/REMU; otherwise they return 0 with latency 1.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rslt,
    output logic            Zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_e          r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_rslt;

    logic            w_accept;
    logic            w_iter;
    logic            w_md_start;
    logic            w_md_busy;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;
    logic [XLEN-1:0] w_alu;
    logic [SHW-1:0]  w_shamt;

    assign w_shamt    = B[SHW-1:0];
    assign w_accept   = in_valid && in_ready;
    assign w_iter     = is_iter_op(ctrl);
    assign w_md_start = w_accept && w_iter;

    always_comb begin
        w_alu = '0;
        case (ctrl)
            OP_AND:  w_alu = A & B;
            OP_OR:   w_alu = A | B;
            OP_ADD:  w_alu = A + B;
            OP_SUB:  w_alu = A - B;
            OP_SLL:  w_alu = A << w_shamt;
            OP_SRL:  w_alu = A >> w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(A) >>> w_shamt);
            OP_SLT:  w_alu = {{(XLEN - 1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: w_alu = {{(XLEN - 1){1'b0}}, (A < B)};
            default: w_alu = '0;
        endcase
    end

    alu_seq_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_md_start),
        .i_op     (ctrl),
        .i_a      (A),
        .i_b      (B),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_rslt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_iter) begin
                            r_state <= ITER;
                        end else begin
                            r_rslt      <= w_alu;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                ITER: begin
                    if (w_md_done) begin
                        r_rslt      <= w_md_result;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign in_ready  = rst_n && (r_state == IDLE) && !w_md_busy;
    assign out_valid = r_out_valid;
    assign rslt      = r_rslt;
    assign Zero      = (r_rslt == '0);

endmodule
